fsm_timer: RTL and testbench

- Parametrised successor of the team's single-channel trigger/count/done FSM.
- Programmable terminal count is captured at trigger, with one-shot or periodic mode selectable per trigger.
- Provides an abort input, busy and count visibility, and a saturating done-event counter.
- Sits beside control FSMs as a generic delay/period generator; `done` drives downstream strobes.

---
 rtl/fsm_timer_pkg.sv | 17 +
 rtl/fsm_timer_evt_cnt.sv | 36 +++
 rtl/fsm_timer.sv | 115 +++++++++++
 tb/tb_fsm_timer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fsm_timer_pkg.sv
// Shared types and defaults for the fsm_timer delay/period generator.
package fsm_timer_pkg;

  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned EVT_W_DEF = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  typedef enum logic {
    ONE_SHOT = 1'b0,
    PERIODIC = 1'b1
  } mode_t;

endpackage

// File: rtl/fsm_timer_evt_cnt.sv
// Saturating event counter with synchronous clear; clear beats increment.
module fsm_timer_evt_cnt #(
  parameter int unsigned EVT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [EVT_W-1:0] cnt
);

  logic [EVT_W-1:0] cnt_q;
  logic [EVT_W-1:0] cnt_d;

  // Next count: clear, saturating increment, or hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {EVT_W{1'b1}})) begin
      cnt_d = cnt_q + EVT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/fsm_timer.sv
// Trigger/count/done timer with programmable terminal count, one-shot or
// periodic mode, abort, and a saturating done-event counter.
// Optional build macro FSM_TIMER_RETRIGGER_EN: a trigger while ACTIVE
// restarts the timer with freshly sampled limit and mode.
module fsm_timer
  import fsm_timer_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned EVT_W = EVT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trigger,
  input  logic             abort,
  input  logic             periodic,
  input  logic [CNT_W-1:0] limit,
  input  logic             evt_clr,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic [EVT_W-1:0] evt_cnt
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  mode_t            mode_q,  mode_d;
  logic             done_c;
  logic             busy_c;
  logic             restart_c;
  logic             terminal_c;

  // Retrigger qualifier: only meaningful while ACTIVE
`ifdef FSM_TIMER_RETRIGGER_EN
  assign restart_c = trigger;
`else
  assign restart_c = 1'b0;
`endif

  assign terminal_c = (count_q == limit_q);

  // Next-state, datapath and output decode
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
    mode_d  = mode_q;
    done_c  = 1'b0;
    busy_c  = 1'b0;

    unique case (state_q)
      IDLE: begin
        count_d = '0;
        if (trigger && !abort) begin
          state_d = ACTIVE;
          limit_d = limit;
          mode_d  = mode_t'(periodic);
        end
      end

      ACTIVE: begin
        busy_c = 1'b1;
        if (abort) begin
          state_d = IDLE;
          count_d = '0;
        end else begin
          // Terminal count still reports done even when a restart lands on it
          done_c = terminal_c;
          if (restart_c) begin
            count_d = '0;
            limit_d = limit;
            mode_d  = mode_t'(periodic);
          end else if (terminal_c) begin
            count_d = '0;
            if (mode_q == ONE_SHOT) begin
              state_d = IDLE;
            end
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
    endcase
  end

  // All timer state in one register bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      limit_q <= '0;
      mode_q  <= ONE_SHOT;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
      mode_q  <= mode_d;
    end
  end

  fsm_timer_evt_cnt #(
    .EVT_W (EVT_W)
  ) u_evt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (done_c),
    .clr   (evt_clr),
    .cnt   (evt_cnt)
  );

  assign done  = done_c;
  assign busy  = busy_c;
  assign count = count_q;

endmodule

// File: tb/tb_fsm_timer.sv
// Self-checking bench for fsm_timer: directed scenarios plus random stimulus,
// compared against a cycle-indexed deadline model.
`timescale 1ns/1ps
module tb_fsm_timer;

`ifdef FSM_TIMER_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif
  localparam int EVT_MAX = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       trigger, abort, periodic, evt_clr;
  logic [7:0] limit;
  logic       done, busy;
  logic [7:0] count;
  logic [3:0] evt_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: timer described by absolute cycle numbers
  int cyc = 0;
  bit m_active = 1'b0;
  bit m_per = 1'b0;
  int m_lim = 0;
  int m_start = 0;
  int m_deadline = 0;
  int m_evt = 0;
  int busy_seen = 0;
  int done_seen = 0;

  always #5 clk = ~clk;

  fsm_timer #(.CNT_W(8), .EVT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .trigger  (trigger),
    .abort    (abort),
    .periodic (periodic),
    .limit    (limit),
    .evt_clr  (evt_clr),
    .done     (done),
    .busy     (busy),
    .count    (count),
    .evt_cnt  (evt_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void m_launch(input int lim, input bit per);
    m_active   = 1'b1;
    m_lim      = lim;
    m_per      = per;
    m_start    = cyc + 1;
    m_deadline = cyc + 1 + lim;
  endfunction

  // One clock cycle: drive inputs, check outputs, advance the model
  task automatic step(input bit trg, input bit abt, input bit per,
                      input logic [7:0] lim, input bit clr);
    bit e_done;
    @(negedge clk);
    trigger  = trg;
    abort    = abt;
    periodic = per;
    limit    = lim;
    evt_clr  = clr;
    #1;
    e_done = m_active && !abt && (cyc == m_deadline);
    check("done",    32'(done),    32'(e_done));
    check("busy",    32'(busy),    32'(m_active));
    check("count",   32'(count),   m_active ? 32'(cyc - m_start) : 32'd0);
    check("evt_cnt", 32'(evt_cnt), 32'(m_evt));
    if (busy) busy_seen++;
    if (done) done_seen++;

    if (clr) m_evt = 0;
    else if (e_done && m_evt < EVT_MAX) m_evt++;

    if (m_active) begin
      if (abt) m_active = 1'b0;
      else if (RETRIG && trg) m_launch(int'(lim), per);
      else if (e_done) begin
        if (m_per) m_launch(m_lim, m_per);
        else m_active = 1'b0;
      end
    end else if (trg && !abt) begin
      m_launch(int'(lim), per);
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  initial begin
    int d_at;
    rst_n = 1'b0; trigger = 1'b0; abort = 1'b0; periodic = 1'b0;
    limit = 8'd0; evt_clr = 1'b0;
    #1;
    check("rst_done",  32'(done),    32'd0);
    check("rst_busy",  32'(busy),    32'd0);
    check("rst_count", 32'(count),   32'd0);
    check("rst_evt",   32'(evt_cnt), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // One-shot, limit 10: 11 busy cycles, one done
    idle(2);
    busy_seen = 0; done_seen = 0;
    step(1'b1, 1'b0, 1'b0, 8'd10, 1'b0);
    idle(14);
    check("os10_busy_cycles", 32'(busy_seen), 32'd11);
    check("os10_dones",       32'(done_seen), 32'd1);
    check("os10_evt",         32'(evt_cnt),   32'd1);

    // Periodic, limit 3: five pulses then abort
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 8'd3, 1'b0);
    done_seen = 0;
    idle(20);
    check("per3_dones", 32'(done_seen), 32'd5);
    step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    check("per3_evt", 32'(evt_cnt), 32'd5);
    done_seen = 0;
    idle(8);
    check("per3_after_abort", 32'(done_seen), 32'd0);

    // Limit 0 one-shot, then limit 255 latency
    step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    idle(3);
    step(1'b1, 1'b0, 1'b0, 8'd255, 1'b0);
    d_at = -1;
    for (int i = 1; i <= 260; i++) begin
      step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
      if (done) d_at = i;
    end
    check("l255_latency", 32'(d_at), 32'd256);

    // Abort coinciding with terminal count; trigger+abort in IDLE
    step(1'b1, 1'b0, 1'b0, 8'd2, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    check("abort_at_term_done", 32'(done), 32'd0);
    idle(2);
    step(1'b1, 1'b1, 1'b1, 8'd4, 1'b0);
    idle(3);
    check("trig_abort_idle", 32'(busy), 32'd0);

    // Saturation at 15, then clear coinciding with done
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 8'd0, 1'b0);
    idle(20);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    check("sat_evt", 32'(evt_cnt), 32'd15);
    check("clr_with_done", 32'(done), 32'd1);
    step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    check("clr_wins", 32'(evt_cnt), 32'd0);
    idle(2);

    // Trigger at count 5 while ACTIVE, limit 10
    step(1'b1, 1'b0, 1'b0, 8'd10, 1'b0);
    d_at = -1;
    for (int i = 1; i <= 25; i++) begin
      step((i == 6), 1'b0, 1'b0, 8'd10, 1'b0);
      if (done) d_at = i;
    end
    check("retrig_done_at", 32'(d_at), RETRIG ? 32'd17 : 32'd11);

    // Reset mid-count forces everything to zero immediately
    step(1'b1, 1'b0, 1'b1, 8'd20, 1'b0);
    idle(7);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_done",  32'(done),    32'd0);
    check("mid_rst_busy",  32'(busy),    32'd0);
    check("mid_rst_count", 32'(count),   32'd0);
    check("mid_rst_evt",   32'(evt_cnt), 32'd0);
    m_active = 1'b0;
    m_evt = 0;
    @(negedge clk);
    trigger = 1'b0; abort = 1'b0; evt_clr = 1'b0;
    rst_n = 1'b1;
    cyc++;
    idle(3);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(7) == 0), ($urandom_range(31) == 0),
           1'($urandom_range(1)),
           ($urandom_range(7) == 0) ? 8'($urandom) : 8'($urandom_range(12)),
           ($urandom_range(63) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
